// File: rtl/vga_sync_gen.sv
// vga_sync_gen: parametrised VGA timing generator.
// Produces the pixel tick, pixel coordinates, sync and video-enable outputs
// (the last three delayed by PIPE clocks), a frame-start strobe and a
// frame-counted blink signal for the text overlay.
module vga_sync_gen #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int CW           = 10,
    parameter int CLK_DIV      = 2,
    parameter int SYNC_POL     = 0,
    parameter int PIPE         = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic          clk,
    input  logic          reset,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          p_tick,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          frame_start,
    output logic          blink
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam int              DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST   = DW'(CLK_DIV - 1);
    localparam int              FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0]   FRAME_LAST = FW'(BLINK_FRAMES - 1);

    // Sync output levels when asserted / deasserted.
    localparam logic SYNC_ACT  = (SYNC_POL != 0);
    localparam logic SYNC_IDLE = (SYNC_POL == 0);

    logic [DW-1:0] div_cnt;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [FW-1:0] frame_cnt;
    logic          hs_raw;
    logic          vs_raw;
    logic          vid_raw;
    logic          hs_lvl;
    logic          vs_lvl;

    assign pixel_x = h_cnt;
    assign pixel_y = v_cnt;

    // Clock divider producing a registered one-clk pixel tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            p_tick  <= 1'b0;
        end else begin
            p_tick <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST) div_cnt <= '0;
            else                     div_cnt <= div_cnt + 1'b1;
        end
    end

    // Horizontal/vertical counters and the frame-wrap strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= p_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);
            if (p_tick) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    if (v_cnt == V_LAST) v_cnt <= '0;
                    else                 v_cnt <= v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    // Frame counter that toggles blink every BLINK_FRAMES frames.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
            blink     <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
                blink     <= ~blink;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Decode sync and active-area flags from the current counters.
    always_comb begin
        hs_raw  = (h_cnt >= H_SS) && (h_cnt <= H_SE);
        vs_raw  = (v_cnt >= V_SS) && (v_cnt <= V_SE);
        vid_raw = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_lvl  = hs_raw ? SYNC_ACT : SYNC_IDLE;
        vs_lvl  = vs_raw ? SYNC_ACT : SYNC_IDLE;
    end

    generate
        if (PIPE == 0) begin : g_direct
            // Counters at (0,0) decode as active video, so reset gates the
            // combinational outputs to keep them deasserted while held.
            always_comb begin
                hsync    = reset ? hs_lvl  : SYNC_IDLE;
                vsync    = reset ? vs_lvl  : SYNC_IDLE;
                video_on = reset ? vid_raw : 1'b0;
            end
        end else begin : g_pipe
            logic [PIPE-1:0] hs_sr;
            logic [PIPE-1:0] vs_sr;
            logic [PIPE-1:0] vid_sr;

            // Free-running delay line, clocked every clk to match overlay latency.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    hs_sr  <= {PIPE{SYNC_IDLE}};
                    vs_sr  <= {PIPE{SYNC_IDLE}};
                    vid_sr <= '0;
                end else begin
                    hs_sr  <= (hs_sr  << 1) | PIPE'(hs_lvl);
                    vs_sr  <= (vs_sr  << 1) | PIPE'(vs_lvl);
                    vid_sr <= (vid_sr << 1) | PIPE'(vid_raw);
                end
            end

            assign hsync    = hs_sr[PIPE-1];
            assign vsync    = vs_sr[PIPE-1];
            assign video_on = vid_sr[PIPE-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed testbench for vga_sync_gen: default timing, a wide-line/short-frame
// variant, and a tiny frame with and without output pipelining.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default configuration (PIPE=2, CLK_DIV=2)
    logic d_hs, d_vs, d_vid, d_tk, d_fs, d_bl;
    logic [9:0] d_x, d_y;
    // Default horizontal, short vertical, CLK_DIV=1, PIPE=0
    logic h_hs, h_vs, h_vid, h_tk, h_fs, h_bl;
    logic [9:0] h_x, h_y;
    // Small frame, PIPE=0, active-high sync
    logic s_hs, s_vs, s_vid, s_tk, s_fs, s_bl;
    logic [9:0] s_x, s_y;
    // Small frame, PIPE=3, active-high sync
    logic p_hs, p_vs, p_vid, p_tk, p_fs, p_bl;
    logic [9:0] p_x, p_y;

    vga_sync_gen u_def (
        .clk(clk), .reset(reset), .hsync(d_hs), .vsync(d_vs), .video_on(d_vid),
        .p_tick(d_tk), .pixel_x(d_x), .pixel_y(d_y), .frame_start(d_fs), .blink(d_bl)
    );

    vga_sync_gen #(
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .CLK_DIV(1), .PIPE(0)
    ) u_h0 (
        .clk(clk), .reset(reset), .hsync(h_hs), .vsync(h_vs), .video_on(h_vid),
        .p_tick(h_tk), .pixel_x(h_x), .pixel_y(h_y), .frame_start(h_fs), .blink(h_bl)
    );

    vga_sync_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .SYNC_POL(1), .PIPE(0), .BLINK_FRAMES(2)
    ) u_sm0 (
        .clk(clk), .reset(reset), .hsync(s_hs), .vsync(s_vs), .video_on(s_vid),
        .p_tick(s_tk), .pixel_x(s_x), .pixel_y(s_y), .frame_start(s_fs), .blink(s_bl)
    );

    vga_sync_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .SYNC_POL(1), .PIPE(3), .BLINK_FRAMES(2)
    ) u_sm3 (
        .clk(clk), .reset(reset), .hsync(p_hs), .vsync(p_vs), .video_on(p_vid),
        .p_tick(p_tk), .pixel_x(p_x), .pixel_y(p_y), .frame_start(p_fs), .blink(p_bl)
    );

    int n, m, xi, yi;
    logic [9:0] ex, ey;
    logic e_tk, e_hs, e_vs, e_vid, e_fs, e_bl;

    // Reset pulse; returns at a falling edge just after release, so the
    // next rising edge is edge k=1 of the count.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (d_hs !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b expected 1", d_hs); end
        checks++; if (d_vs !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b expected 1", d_vs); end
        checks++; if (d_vid !== 1'b0) begin errors++; $display("FAIL reset_video_on: got %b expected 0", d_vid); end
        checks++; if (d_tk !== 1'b0) begin errors++; $display("FAIL reset_p_tick: got %b expected 0", d_tk); end
        checks++; if (d_x !== 10'd0) begin errors++; $display("FAIL reset_pixel_x: got %0d expected 0", d_x); end
        checks++; if (d_y !== 10'd0) begin errors++; $display("FAIL reset_pixel_y: got %0d expected 0", d_y); end
        checks++; if (d_bl !== 1'b0) begin errors++; $display("FAIL reset_blink: got %b expected 0", d_bl); end
        checks++; if (d_fs !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", d_fs); end
        checks++; if (h_vid !== 1'b0) begin errors++; $display("FAIL reset_video_on_pipe0: got %b expected 0", h_vid); end
        checks++; if (s_hs !== 1'b0) begin errors++; $display("FAIL reset_hsync_pol1: got %b expected 0", s_hs); end
    endtask

    // CLK_DIV=2: tick after even edges; pixel count after edge k is (k-1)/2.
    task automatic test_tick_line();
        do_reset();
        for (int k = 1; k <= 1610; k++) begin
            @(negedge clk);
            n = (k - 1) / 2;
            e_tk = (k >= 2) && (k % 2 == 0);
            ex = 10'(n % 800);
            ey = 10'(n / 800);
            m = (k >= 3) ? (k - 3) / 2 : 0;
            xi = m % 800;
            yi = m / 800;
            e_hs = (k < 2) ? 1'b1 : !(xi >= 656 && xi <= 751);
            e_vid = (k < 2) ? 1'b0 : (xi < 640 && yi < 480);
            checks++; if (d_tk !== e_tk) begin errors++; $display("FAIL line_p_tick k=%0d: got %b expected %b", k, d_tk, e_tk); end
            checks++; if (d_x !== ex) begin errors++; $display("FAIL line_pixel_x k=%0d: got %0d expected %0d", k, d_x, ex); end
            checks++; if (d_y !== ey) begin errors++; $display("FAIL line_pixel_y k=%0d: got %0d expected %0d", k, d_y, ey); end
            checks++; if (d_hs !== e_hs) begin errors++; $display("FAIL line_hsync k=%0d: got %b expected %b", k, d_hs, e_hs); end
            checks++; if (d_vs !== 1'b1) begin errors++; $display("FAIL line_vsync k=%0d: got %b expected 1", k, d_vs); end
            checks++; if (d_vid !== e_vid) begin errors++; $display("FAIL line_video_on k=%0d: got %b expected %b", k, d_vid, e_vid); end
            checks++; if (d_fs !== 1'b0) begin errors++; $display("FAIL line_frame_start k=%0d: got %b expected 0", k, d_fs); end
        end
    endtask

    // CLK_DIV=1, PIPE=0, 800x12 frame: pixel count after edge k is k-1.
    task automatic test_sync_placement();
        do_reset();
        for (int k = 1; k <= 9700; k++) begin
            @(negedge clk);
            n = k - 1;
            xi = n % 800;
            yi = (n / 800) % 12;
            ex = 10'(xi);
            ey = 10'(yi);
            e_hs = !(xi >= 656 && xi <= 751);
            e_vs = !(yi == 8 || yi == 9);
            e_vid = (xi < 640) && (yi < 6);
            e_fs = (k == 9601);
            checks++; if (h_tk !== 1'b1) begin errors++; $display("FAIL sync_p_tick k=%0d: got %b expected 1", k, h_tk); end
            checks++; if (h_x !== ex) begin errors++; $display("FAIL sync_pixel_x k=%0d: got %0d expected %0d", k, h_x, ex); end
            checks++; if (h_y !== ey) begin errors++; $display("FAIL sync_pixel_y k=%0d: got %0d expected %0d", k, h_y, ey); end
            checks++; if (h_hs !== e_hs) begin errors++; $display("FAIL sync_hsync k=%0d x=%0d: got %b expected %b", k, xi, h_hs, e_hs); end
            checks++; if (h_vs !== e_vs) begin errors++; $display("FAIL sync_vsync k=%0d y=%0d: got %b expected %b", k, yi, h_vs, e_vs); end
            checks++; if (h_vid !== e_vid) begin errors++; $display("FAIL sync_video_on k=%0d: got %b expected %b", k, h_vid, e_vid); end
            checks++; if (h_fs !== e_fs) begin errors++; $display("FAIL sync_frame_start k=%0d: got %b expected %b", k, h_fs, e_fs); end
            checks++; if (h_bl !== 1'b0) begin errors++; $display("FAIL sync_blink k=%0d: got %b expected 0", k, h_bl); end
        end
    endtask

    // 8x6 frame = 48 clks; frame_start after edges 49, 97, ...; blink toggles at 98, 194, ...
    task automatic test_small_frame();
        do_reset();
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            n = k - 1;
            xi = n % 8;
            yi = (n / 8) % 6;
            ex = 10'(xi);
            ey = 10'(yi);
            e_fs = (k >= 49) && ((k - 49) % 48 == 0);
            e_bl = (k >= 98) && (((k - 98) / 96) % 2 == 0);
            e_hs = (xi >= 5 && xi <= 6);
            e_vs = (yi == 4);
            e_vid = (xi < 4) && (yi < 3);
            checks++; if (s_x !== ex) begin errors++; $display("FAIL small_pixel_x k=%0d: got %0d expected %0d", k, s_x, ex); end
            checks++; if (s_y !== ey) begin errors++; $display("FAIL small_pixel_y k=%0d: got %0d expected %0d", k, s_y, ey); end
            checks++; if (s_fs !== e_fs) begin errors++; $display("FAIL small_frame_start k=%0d: got %b expected %b", k, s_fs, e_fs); end
            checks++; if (s_bl !== e_bl) begin errors++; $display("FAIL small_blink k=%0d: got %b expected %b", k, s_bl, e_bl); end
            checks++; if (s_hs !== e_hs) begin errors++; $display("FAIL small_hsync k=%0d: got %b expected %b", k, s_hs, e_hs); end
            checks++; if (s_vs !== e_vs) begin errors++; $display("FAIL small_vsync k=%0d: got %b expected %b", k, s_vs, e_vs); end
            checks++; if (s_vid !== e_vid) begin errors++; $display("FAIL small_video_on k=%0d: got %b expected %b", k, s_vid, e_vid); end
        end
    endtask

    // PIPE=3: sync/video after edge k reflect the counters after edge k-3.
    task automatic test_pipe_align();
        do_reset();
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            n = k - 1;
            ex = 10'(n % 8);
            ey = 10'((n / 8) % 6);
            m = (k >= 4) ? k - 4 : 0;
            xi = m % 8;
            yi = (m / 8) % 6;
            e_hs = (k >= 3) && (xi >= 5 && xi <= 6);
            e_vs = (k >= 3) && (yi == 4);
            e_vid = (k >= 3) && (xi < 4) && (yi < 3);
            checks++; if (p_tk !== 1'b1) begin errors++; $display("FAIL pipe_p_tick k=%0d: got %b expected 1", k, p_tk); end
            checks++; if (p_x !== ex) begin errors++; $display("FAIL pipe_pixel_x k=%0d: got %0d expected %0d", k, p_x, ex); end
            checks++; if (p_y !== ey) begin errors++; $display("FAIL pipe_pixel_y k=%0d: got %0d expected %0d", k, p_y, ey); end
            checks++; if (p_hs !== e_hs) begin errors++; $display("FAIL pipe_hsync k=%0d: got %b expected %b", k, p_hs, e_hs); end
            checks++; if (p_vs !== e_vs) begin errors++; $display("FAIL pipe_vsync k=%0d: got %b expected %b", k, p_vs, e_vs); end
            checks++; if (p_vid !== e_vid) begin errors++; $display("FAIL pipe_video_on k=%0d: got %b expected %b", k, p_vid, e_vid); end
        end
    endtask

    // Run into the second frame (frame_cnt=1), reset at h=5,v=2, then verify
    // the restart: blink must first toggle only after two fresh frames.
    task automatic test_reset_mid();
        do_reset();
        repeat (70) @(negedge clk);
        checks++; if (s_x !== 10'd5) begin errors++; $display("FAIL mid_pre_x: got %0d expected 5", s_x); end
        checks++; if (s_y !== 10'd2) begin errors++; $display("FAIL mid_pre_y: got %0d expected 2", s_y); end
        checks++; if (s_hs !== 1'b1) begin errors++; $display("FAIL mid_pre_hsync: got %b expected 1", s_hs); end
        reset = 1'b0;
        #1;
        checks++; if (s_hs !== 1'b0) begin errors++; $display("FAIL mid_hsync: got %b expected 0", s_hs); end
        checks++; if (s_vs !== 1'b0) begin errors++; $display("FAIL mid_vsync: got %b expected 0", s_vs); end
        checks++; if (s_vid !== 1'b0) begin errors++; $display("FAIL mid_video_on: got %b expected 0", s_vid); end
        checks++; if (s_tk !== 1'b0) begin errors++; $display("FAIL mid_p_tick: got %b expected 0", s_tk); end
        checks++; if (s_x !== 10'd0) begin errors++; $display("FAIL mid_pixel_x: got %0d expected 0", s_x); end
        checks++; if (s_y !== 10'd0) begin errors++; $display("FAIL mid_pixel_y: got %0d expected 0", s_y); end
        checks++; if (s_fs !== 1'b0) begin errors++; $display("FAIL mid_frame_start: got %b expected 0", s_fs); end
        checks++; if (s_bl !== 1'b0) begin errors++; $display("FAIL mid_blink: got %b expected 0", s_bl); end
        checks++; if (p_hs !== 1'b0) begin errors++; $display("FAIL mid_pipe_hsync: got %b expected 0", p_hs); end
        checks++; if (p_vs !== 1'b0) begin errors++; $display("FAIL mid_pipe_vsync: got %b expected 0", p_vs); end
        checks++; if (p_vid !== 1'b0) begin errors++; $display("FAIL mid_pipe_video_on: got %b expected 0", p_vid); end
        checks++; if (p_fs !== 1'b0) begin errors++; $display("FAIL mid_pipe_frame_start: got %b expected 0", p_fs); end
        checks++; if (p_bl !== 1'b0) begin errors++; $display("FAIL mid_pipe_blink: got %b expected 0", p_bl); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            n = k - 1;
            ex = 10'(n % 8);
            ey = 10'((n / 8) % 6);
            e_fs = (k == 49) || (k == 97);
            e_bl = (k >= 98);
            checks++; if (s_x !== ex) begin errors++; $display("FAIL mid_post_x k=%0d: got %0d expected %0d", k, s_x, ex); end
            checks++; if (s_y !== ey) begin errors++; $display("FAIL mid_post_y k=%0d: got %0d expected %0d", k, s_y, ey); end
            checks++; if (s_fs !== e_fs) begin errors++; $display("FAIL mid_post_frame_start k=%0d: got %b expected %b", k, s_fs, e_fs); end
            checks++; if (s_bl !== e_bl) begin errors++; $display("FAIL mid_post_blink k=%0d: got %b expected %b", k, s_bl, e_bl); end
        end
    endtask

    initial begin
        test_reset();
        test_tick_line();
        test_sync_placement();
        test_small_frame();
        test_pipe_align();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
